// File: rtl/fir_filter_tdm.sv
//------------------------------------------------------------------------------
// Module   : fir_filter_tdm
// Brief    : Time-multiplexed FIR filter with one MAC and run-time coefficients.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fir_filter_tdm #(
  parameter int WW_INPUT  = 8,
  parameter int WW_COEFF  = 8,
  parameter int WW_OUTPUT = 8,
  parameter int N_TAPS    = 15,
  localparam int WW_ADDR  = $clog2(N_TAPS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WW_INPUT-1:0]  i_signal,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic [WW_OUTPUT-1:0] o_signal,
  input  logic                 i_coeff_we,
  input  logic [WW_ADDR-1:0]   i_coeff_addr,
  input  logic [WW_COEFF-1:0]  i_coeff_data
);

  localparam int WW_PROD = WW_INPUT + WW_COEFF;
  localparam int WW_ACC  = WW_INPUT + WW_COEFF + WW_ADDR;
  localparam int SHIFT   = (WW_INPUT - 2) + (WW_COEFF - 2) - (WW_OUTPUT - 2);

  localparam logic [WW_ADDR:0]             C_N_TAPS    = (WW_ADDR + 1)'(N_TAPS);
  localparam logic [WW_ADDR-1:0]           C_LAST_K    = WW_ADDR'(N_TAPS - 1);
  localparam logic signed [WW_COEFF-1:0]   C_COEFF_ONE = WW_COEFF'(1 << (WW_COEFF - 2));
  localparam logic signed [WW_ACC-1:0]     C_OUT_MAX   = WW_ACC'((1 << (WW_OUTPUT - 1)) - 1);
  localparam logic signed [WW_ACC-1:0]     C_OUT_MIN   = -C_OUT_MAX - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [WW_INPUT-1:0]  r_x     [N_TAPS];
  logic signed [WW_COEFF-1:0]  r_coeff [N_TAPS];
  logic signed [WW_ACC-1:0]    r_acc;
  logic [WW_ADDR-1:0]          r_k;
  logic                        r_valid;
  logic [WW_OUTPUT-1:0]        r_signal;

  logic                        w_idle;
  logic                        w_coeff_wr;
  logic                        w_last;
  logic signed [WW_PROD-1:0]   w_prod;
  logic signed [WW_ACC-1:0]    w_sum;
  logic signed [WW_ACC-1:0]    w_shifted;
  logic [WW_OUTPUT-1:0]        w_sat;

  assign w_idle     = (r_state == S_IDLE);
  assign o_ready    = w_idle & i_en;
  assign o_valid    = r_valid;
  assign o_signal   = r_signal;
  assign w_coeff_wr = i_coeff_we & w_idle & i_en & ({1'b0, i_coeff_addr} < C_N_TAPS);
  assign w_last     = (r_k == C_LAST_K);

  // Full-precision product, sign-extended into the accumulator width
  assign w_prod    = r_coeff[r_k] * r_x[r_k];
  assign w_sum     = r_acc + {{WW_ADDR{w_prod[WW_PROD-1]}}, w_prod};
  assign w_shifted = w_sum >>> SHIFT;

  always_comb begin
    w_sat = w_shifted[WW_OUTPUT-1:0];
    if (w_shifted > C_OUT_MAX) begin
      w_sat = {1'b0, {(WW_OUTPUT-1){1'b1}}};
    end else if (w_shifted < C_OUT_MIN) begin
      w_sat = {1'b1, {(WW_OUTPUT-1){1'b0}}};
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_en) begin
      case (r_state)
        S_IDLE:  if (i_valid)     w_state_next = S_MAC;
        S_MAC:   if (w_last)      w_state_next = S_OUT;
        S_OUT:   if (i_out_ready) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < N_TAPS; k++) begin
        r_x[k]     <= '0;
        r_coeff[k] <= (k == 0) ? C_COEFF_ONE : '0;
      end
      r_acc    <= '0;
      r_k      <= '0;
      r_valid  <= 1'b0;
      r_signal <= '0;
    end else if (i_en) begin
      // Applied before MAC starts, so a write on the acceptance edge is used
      if (w_coeff_wr) begin
        r_coeff[i_coeff_addr] <= i_coeff_data;
      end
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_x[0] <= i_signal;
            for (int k = 1; k < N_TAPS; k++) begin
              r_x[k] <= r_x[k-1];
            end
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        S_MAC: begin
          if (w_last) begin
            r_signal <= w_sat;
            r_valid  <= 1'b1;
          end else begin
            r_acc <= w_sum;
            r_k   <= r_k + 1'b1;
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_filter_tdm.sv
//------------------------------------------------------------------------------
// Module   : tb_fir_filter_tdm
// Brief    : Directed self-checking bench for fir_filter_tdm with scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_filter_tdm;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_en = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_signal = '0;
  logic       o_valid;
  logic       i_out_ready = 1'b1;
  logic [7:0] o_signal;
  logic       i_coeff_we = 1'b0;
  logic [3:0] i_coeff_addr = '0;
  logic [7:0] i_coeff_data = '0;

  logic       valid6 = 1'b0;
  logic       ready6;
  logic [7:0] signal6 = '0;
  logic       ovalid6;
  logic [5:0] osignal6;

  always #5 i_clock = ~i_clock;

  fir_filter_tdm dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_en(i_en),
    .i_valid(i_valid), .o_ready(o_ready), .i_signal(i_signal),
    .o_valid(o_valid), .i_out_ready(i_out_ready), .o_signal(o_signal),
    .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data)
  );

  fir_filter_tdm #(.WW_OUTPUT(6)) dut6 (
    .i_clock(i_clock), .i_reset(i_reset), .i_en(1'b1),
    .i_valid(valid6), .o_ready(ready6), .i_signal(signal6),
    .o_valid(ovalid6), .i_out_ready(1'b1), .o_signal(osignal6),
    .i_coeff_we(1'b0), .i_coeff_addr(4'd0), .i_coeff_data(8'd0)
  );

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int         n_pass = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         accept_cyc = 0;
  string      phase = "reset";
  logic [7:0] sb[$];
  int         mx[15];
  int         mc[15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Reference: full-precision dot product, floor shift by 6, clamp to 8 bits
  function automatic logic [7:0] model_out();
    int sum = 0;
    for (int k = 0; k < 15; k++) sum += mc[k] * mx[k];
    sum = sum >>> 6;
    if (sum > 127) sum = 127;
    if (sum < -128) sum = -128;
    return sum[7:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 15; k++) begin
      mx[k] = 0;
      mc[k] = 0;
    end
    mc[0] = 64;
    sb.delete();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [7:0] s);
    int n = 0;
    i_signal = s;
    i_valid  = 1'b1;
    while (!o_ready && n < 200) begin
      @(posedge i_clock); #1;
      n++;
    end
    if (n >= 200) check({"accept_timeout_", phase}, o_ready, 1);
    for (int k = 14; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = sx8(s);
    sb.push_back(model_out());
    @(posedge i_clock); #1;
    accept_cyc = cyc;
    i_valid = 1'b0;
  endtask

  task automatic wait_out(input int lat, input string tag);
    while (!o_valid && (cyc - accept_cyc) < 100) begin
      @(posedge i_clock); #1;
    end
    check(tag, cyc - accept_cyc, lat);
  endtask

  task automatic write_coeff(input logic [3:0] a, input logic [7:0] d, input bit apply);
    i_coeff_we   = 1'b1;
    i_coeff_addr = a;
    i_coeff_data = d;
    @(posedge i_clock); #1;
    i_coeff_we = 1'b0;
    if (apply) mc[a] = sx8(d);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge i_clock); #1;
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  // Output side of the scoreboard: compare on every output handshake
  always @(negedge i_clock) begin
    if (!i_reset && i_en && o_valid && i_out_ready) begin
      if (sb.size() == 0) check({"unexpected_out_", phase}, sb.size(), 1);
      else check({"out_", phase}, o_signal, sb.pop_front());
    end
  end

  logic [7:0] imp_tab [15] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h03, 8'h08, 8'h0D, 8'h10,
                               8'h0D, 8'h08, 8'h03, 8'h00, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    int a1;
    int n;
    model_reset();
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_signal", o_signal, 0);
    check("rst_ready", o_ready, 1);

    phase = "pass";
    send(8'h20); a1 = accept_cyc;
    wait_out(15, "lat_pass0");
    send(8'hE0);
    check("period", accept_cyc - a1, 17);
    wait_out(15, "lat_pass1");
    send(8'h7F);
    wait_out(15, "lat_pass2");
    drain("drain_pass");

    phase = "impulse";
    do_reset();
    for (int k = 0; k < 15; k++) write_coeff(4'(k), imp_tab[k], 1'b1);
    send(8'h40);
    for (int k = 0; k < 14; k++) send(8'h00);
    drain("drain_impulse");

    phase = "sat";
    do_reset();
    for (int k = 0; k < 15; k++) write_coeff(4'(k), 8'h7F, 1'b1);
    for (int k = 0; k < 15; k++) send(8'h7F);
    drain("drain_sat_pos");
    check("sat_pos_last", o_signal, 8'h7F);
    for (int k = 0; k < 15; k++) send(8'h80);
    drain("drain_sat_neg");
    check("sat_neg_last", o_signal, 8'h80);

    phase = "bp";
    do_reset();
    write_coeff(4'd1, 8'h40, 1'b1);
    i_out_ready = 1'b0;
    send(8'h11);
    wait_out(15, "lat_bp");
    i_signal = 8'h55;
    for (int i = 0; i < 10; i++) begin
      i_valid = (i % 2 == 0);
      @(posedge i_clock); #1;
      check("bp_valid", o_valid, 1);
      check("bp_signal", o_signal, 8'h11);
      check("bp_ready", o_ready, 0);
    end
    i_valid = 1'b0;
    i_out_ready = 1'b1;
    @(posedge i_clock); #1;
    check("bp_release_valid", o_valid, 0);
    check("bp_release_ready", o_ready, 1);
    send(8'h22);
    drain("drain_bp");

    phase = "busy_wr";
    do_reset();
    send(8'h30);
    repeat (3) begin @(posedge i_clock); #1; end
    write_coeff(4'd0, 8'h00, 1'b0);
    wait_out(15, "lat_busy");
    write_coeff(4'd0, 8'h00, 1'b0);
    write_coeff(4'd15, 8'h7F, 1'b0);
    send(8'h30);
    wait_out(15, "lat_busy2");

    phase = "en_low";
    send(8'h18);
    repeat (3) begin @(posedge i_clock); #1; end
    i_en = 1'b0;
    repeat (5) begin @(posedge i_clock); #1; end
    i_en = 1'b1;
    wait_out(20, "lat_en_low");
    drain("drain_en_low");

    phase = "midrst";
    write_coeff(4'd0, 8'h20, 1'b1);
    send(8'h40);
    repeat (4) begin @(posedge i_clock); #1; end
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 1);
    i_reset = 1'b0;
    model_reset();
    send(8'h20);
    wait_out(15, "lat_midrst");
    drain("drain_midrst");

    phase = "trunc6";
    signal6 = 8'h3F;
    valid6 = 1'b1;
    n = 0;
    while (!ready6 && n < 50) begin @(posedge i_clock); #1; n++; end
    @(posedge i_clock); #1;
    valid6 = 1'b0;
    n = 0;
    while (!ovalid6 && n < 50) begin @(posedge i_clock); #1; n++; end
    check("trunc6_signal", osignal6, 6'h0F);
    check("trunc6_lat", n, 15);

    check("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
